axi_master_arbiter: RTL
=======================

// Module: axi_master_arbiter
// PURPOSE
//  NM-to-1 AXI3 arbiter between the cache-side bus masters and the single CPU AXI port.
//  Masters are 0=ICache, 1=DCache, 2=UnCache.
//  Read and write paths arbitrate independently. Each path allows one outstanding burst.
//  Grant is locked from address phase to last beat (R) or to B handshake (W).
// PARAMETERS
//  NM      3   number of masters
//  ADDR_W  32  address width
//  DATA_W  32  data width
//  ID_W    4   AXI id width; m_arid/m_awid = granted master index
// PORTS
//  clk                           in   1          system clock
//  resetn                        in   1          synchronous, active-low reset
//  s_araddr/arlen/arsize/arburst in   NM*{32,8,3,2}  per-master AR payload, master i at slice i
//  s_arvalid / s_arready         in/out NM       per-master AR handshake
//  s_rdata / s_rresp / s_rlast   out  32/2/1     R payload, broadcast to all masters
//  s_rvalid / s_rready           out/in NM       per-master R handshake
//  s_awaddr/awlen/awsize/awburst in   NM*{32,8,3,2}  per-master AW payload
//  s_awvalid / s_awready         in/out NM       per-master AW handshake
//  s_wdata / s_wstrb / s_wlast   in   NM*{32,4,1} per-master W payload
//  s_wvalid / s_wready           in/out NM       per-master W handshake
//  s_bresp                       out  2          B response, broadcast
//  s_bvalid / s_bready           out/in NM       per-master B handshake
//  m_ar{id,addr,len,size,burst,valid} / m_arready   out/in  AXI master AR channel
//  m_r{data,resp,last,valid} / m_rready             in/out  AXI master R channel
//  m_aw{id,addr,len,size,burst,valid} / m_awready   out/in  AXI master AW channel
//  m_w{data,strb,last,valid} / m_wready             in/out  AXI master W channel
//  m_b{resp,valid} / m_bready                       in/out  AXI master B channel
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//   - both FSMs go idle; rd_gnt = wr_gnt = 0.
//   - every valid/ready output is 0; payload outputs are 0.
//   - Reset mid-burst abandons the transfer immediately; no completion is generated.
//  Read FSM:
//   - R_IDLE: if any s_arvalid, latch rd_gnt = pick(s_arvalid) and go to R_ADDR.
//     A request seen in cycle N is presented as m_arvalid in cycle N+1.
//   - R_ADDR: m_arvalid = s_arvalid[rd_gnt]; m_ar* = slice rd_gnt; s_arready[rd_gnt] = m_arready.
//     m_arvalid & m_arready -> R_DATA.
//   - R_DATA: s_rvalid[rd_gnt] = m_rvalid; m_rready = s_rready[rd_gnt].
//     The beat with m_rvalid & m_rready & m_rlast -> R_IDLE.
//   - m_rid is ignored; routing uses rd_gnt only.
//  Write FSM:
//   - W_IDLE: pick wr_gnt from s_awvalid, go to W_ADDR.
//   - W_ADDR: AW routed as in R_ADDR; handshake -> W_DATA.
//   - W_DATA: m_w* = slice wr_gnt; m_wvalid = s_wvalid[wr_gnt]; s_wready[wr_gnt] = m_wready.
//     The beat with m_wvalid & m_wready & m_wlast -> W_RESP.
//   - W_RESP: s_bvalid[wr_gnt] = m_bvalid; m_bready = s_bready[wr_gnt]. Handshake -> W_IDLE.
//  Non-granted masters see every ready/valid as 0. Their requests wait and are never dropped.
//  Read and write FSMs never block each other; the same master may hold both grants at once.
//  Arbitration returns to idle after every transaction, so there is one bubble cycle between back-to-back bursts.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority DCache(1) > UnCache(2) > ICache(0).
//  ARB_ROUND_ROBIN_EN defined:
//   - per-path last-grant pointer, reset to NM-1; the next requester after it wins.
//   - the pointer updates when the path returns to idle.
// STRUCTURE
//  cpu_defs.svh:
//   - axi_master_e {AXI_M_ICACHE, AXI_M_DCACHE, AXI_M_UNCACHE}
//   - arb_rd_state_t {R_IDLE, R_ADDR, R_DATA}
//   - arb_wr_state_t {W_IDLE, W_ADDR, W_DATA, W_RESP}
//  Sub-module axi_arb_pick: combinational picker (req, last_gnt -> gnt).
//  Instantiated once for AR and once for AW.
// TESTING
//  1. Reset: resetn held low 3 cycles with s_arvalid=3'b111.
//     -> all m_*valid, s_*ready, s_*valid are 0. After release, m_arvalid rises 1 cycle later.
//  2. ICache arlen=3 at 0x1fc00000, slave returns 4 beats.
//     -> m_arid=0, m_araddr=0x1fc00000; s_rvalid[0] pulses 4 times; s_rvalid[2:1] stay 0.
//  3. Fixed priority, s_arvalid=3'b111 held.
//     -> grant order DCache, UnCache, ICache only after earlier requests drop.
//     With ARB_ROUND_ROBIN_EN the order is 0,1,2,0 while all are held.
//  4. DCache 4-beat write (wdata 0x11..0x44) concurrent with UnCache 1-beat read.
//     -> both complete. m_wlast only on the 0x44 beat. s_bvalid[1] after B. No cross-routing.
//  5. Slave stalls m_awready 10 cycles, then m_bvalid 5 cycles.
//     -> m_awvalid stable with payload held; s_bvalid[1] asserts only with m_bvalid.
//  6. resetn dropped during beat 2 of a read.
//     -> next cycle idle, all outputs 0; a new request completes normally after reset.

Source files
------------

// File: rtl/axi_master_arbiter_pkg.sv
// Shared types for the AXI master arbiter: master indices and per-path FSM states.
package axi_master_arbiter_pkg;

  typedef enum logic [1:0] {AXI_M_ICACHE, AXI_M_DCACHE, AXI_M_UNCACHE} axi_master_e;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} arb_rd_state_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} arb_wr_state_t;

  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;

endpackage

// File: rtl/axi_master_arbiter_if.sv
// Bus bundle for the arbiter: per-master s_* slices plus the single m_* AXI3 port.
// Modport master is the arbiter's view; modport slave is the caches/CPU-port side.
interface axi_master_arbiter_if
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned NM     = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned SW = DATA_W / 8;

  logic [NM*ADDR_W-1:0]      s_araddr;
  logic [NM*AXI_LEN_W-1:0]   s_arlen;
  logic [NM*AXI_SIZE_W-1:0]  s_arsize;
  logic [NM*AXI_BURST_W-1:0] s_arburst;
  logic [NM-1:0]             s_arvalid, s_arready;
  logic [DATA_W-1:0]         s_rdata;
  logic [AXI_RESP_W-1:0]     s_rresp;
  logic                      s_rlast;
  logic [NM-1:0]             s_rvalid, s_rready;
  logic [NM*ADDR_W-1:0]      s_awaddr;
  logic [NM*AXI_LEN_W-1:0]   s_awlen;
  logic [NM*AXI_SIZE_W-1:0]  s_awsize;
  logic [NM*AXI_BURST_W-1:0] s_awburst;
  logic [NM-1:0]             s_awvalid, s_awready;
  logic [NM*DATA_W-1:0]      s_wdata;
  logic [NM*SW-1:0]          s_wstrb;
  logic [NM-1:0]             s_wlast, s_wvalid, s_wready;
  logic [AXI_RESP_W-1:0]     s_bresp;
  logic [NM-1:0]             s_bvalid, s_bready;

  logic [ID_W-1:0]           m_arid, m_awid;
  logic [ADDR_W-1:0]         m_araddr, m_awaddr;
  logic [AXI_LEN_W-1:0]      m_arlen, m_awlen;
  logic [AXI_SIZE_W-1:0]     m_arsize, m_awsize;
  logic [AXI_BURST_W-1:0]    m_arburst, m_awburst;
  logic                      m_arvalid, m_arready, m_awvalid, m_awready;
  logic [DATA_W-1:0]         m_rdata, m_wdata;
  logic [AXI_RESP_W-1:0]     m_rresp, m_bresp;
  logic                      m_rlast, m_rvalid, m_rready;
  logic [SW-1:0]             m_wstrb;
  logic                      m_wlast, m_wvalid, m_wready;
  logic                      m_bvalid, m_bready;

  modport master (
    input  s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
           s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
           s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
           m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           m_awready, m_wready, m_bresp, m_bvalid,
    output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
           s_awready, s_wready, s_bresp, s_bvalid,
           m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
           m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
           m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
  );

  modport slave (
    output s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
           s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
           s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
           m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           m_awready, m_wready, m_bresp, m_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
           s_awready, s_wready, s_bresp, s_bvalid,
           m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
           m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
           m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready
  );

endinterface

// File: rtl/axi_master_arbiter_pick.sv
// Combinational grant picker. Fixed priority 1 > 2 > ... > NM-1 > 0 by default;
// round robin after last_gnt when ARB_ROUND_ROBIN_EN is defined.
module axi_arb_pick
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned NM = 3,
  parameter int unsigned GW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last_gnt,
  output logic [GW-1:0] gnt
);

  logic found;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt   = last_gnt;
    found = 1'b0;
    for (int unsigned k = 1; k <= NM; k++) begin
      if (!found && req[(32'(last_gnt) + k) % NM]) begin
        gnt   = GW'((32'(last_gnt) + k) % NM);
        found = 1'b1;
      end
    end
  end
`else
  // ICache (index 0) is the fallback: it wins only when no other master requests.
  always_comb begin
    gnt   = GW'(AXI_M_ICACHE);
    found = 1'b0;
    for (int unsigned i = 1; i < NM; i++) begin
      if (!found && req[i]) begin
        gnt   = GW'(i);
        found = 1'b1;
      end
    end
  end

  logic unused_pick;
  assign unused_pick = ^{last_gnt, req[0]};
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// NM-to-1 AXI3 arbiter: independent read/write FSMs, one outstanding burst per path,
// grant locked until last R beat / B handshake. Optional macro: ARB_ROUND_ROBIN_EN.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned NM     = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  axi_master_arbiter_if.master bus
);

  localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SW = DATA_W / 8;

  arb_rd_state_t rd_st_q, rd_st_d;
  arb_wr_state_t wr_st_q, wr_st_d;
  logic [GW-1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic [GW-1:0] rd_pick, wr_pick, rd_last_sel, wr_last_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rd_last_q, rd_last_d, wr_last_q, wr_last_d;
  assign rd_last_sel = rd_last_q;
  assign wr_last_sel = wr_last_q;
`else
  assign rd_last_sel = GW'(NM - 1);
  assign wr_last_sel = GW'(NM - 1);
`endif

  axi_arb_pick #(.NM(NM), .GW(GW)) u_pick_ar (
    .req(bus.s_arvalid), .last_gnt(rd_last_sel), .gnt(rd_pick)
  );

  axi_arb_pick #(.NM(NM), .GW(GW)) u_pick_aw (
    .req(bus.s_awvalid), .last_gnt(wr_last_sel), .gnt(wr_pick)
  );

  // Routing is gated by state so idle paths and non-granted masters see all zeros.
  always_comb begin
    bus.s_arready = '0; bus.s_rvalid = '0; bus.s_awready = '0;
    bus.s_wready  = '0; bus.s_bvalid = '0;
    bus.s_rdata   = '0; bus.s_rresp  = '0; bus.s_rlast   = 1'b0; bus.s_bresp = '0;
    bus.m_arid    = '0; bus.m_araddr = '0; bus.m_arlen   = '0;
    bus.m_arsize  = '0; bus.m_arburst = '0; bus.m_arvalid = 1'b0; bus.m_rready = 1'b0;
    bus.m_awid    = '0; bus.m_awaddr = '0; bus.m_awlen   = '0;
    bus.m_awsize  = '0; bus.m_awburst = '0; bus.m_awvalid = 1'b0;
    bus.m_wdata   = '0; bus.m_wstrb  = '0; bus.m_wlast   = 1'b0; bus.m_wvalid = 1'b0;
    bus.m_bready  = 1'b0;
    if (rd_st_q == R_ADDR) bus.m_arid = ID_W'(rd_gnt_q);
    if (rd_st_q == R_DATA) begin
      bus.s_rdata = bus.m_rdata; bus.s_rresp = bus.m_rresp; bus.s_rlast = bus.m_rlast;
    end
    if (wr_st_q == W_ADDR) bus.m_awid = ID_W'(wr_gnt_q);
    if (wr_st_q == W_RESP) bus.s_bresp = bus.m_bresp;
    for (int unsigned i = 0; i < NM; i++) begin
      if (GW'(i) == rd_gnt_q) begin
        if (rd_st_q == R_ADDR) begin
          bus.m_arvalid    = bus.s_arvalid[i];
          bus.m_araddr     = bus.s_araddr[i*ADDR_W +: ADDR_W];
          bus.m_arlen      = bus.s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
          bus.m_arsize     = bus.s_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
          bus.m_arburst    = bus.s_arburst[i*AXI_BURST_W +: AXI_BURST_W];
          bus.s_arready[i] = bus.m_arready;
        end
        if (rd_st_q == R_DATA) begin
          bus.s_rvalid[i] = bus.m_rvalid;
          bus.m_rready    = bus.s_rready[i];
        end
      end
      if (GW'(i) == wr_gnt_q) begin
        if (wr_st_q == W_ADDR) begin
          bus.m_awvalid    = bus.s_awvalid[i];
          bus.m_awaddr     = bus.s_awaddr[i*ADDR_W +: ADDR_W];
          bus.m_awlen      = bus.s_awlen[i*AXI_LEN_W +: AXI_LEN_W];
          bus.m_awsize     = bus.s_awsize[i*AXI_SIZE_W +: AXI_SIZE_W];
          bus.m_awburst    = bus.s_awburst[i*AXI_BURST_W +: AXI_BURST_W];
          bus.s_awready[i] = bus.m_awready;
        end
        if (wr_st_q == W_DATA) begin
          bus.m_wdata     = bus.s_wdata[i*DATA_W +: DATA_W];
          bus.m_wstrb     = bus.s_wstrb[i*SW +: SW];
          bus.m_wlast     = bus.s_wlast[i];
          bus.m_wvalid    = bus.s_wvalid[i];
          bus.s_wready[i] = bus.m_wready;
        end
        if (wr_st_q == W_RESP) begin
          bus.s_bvalid[i] = bus.m_bvalid;
          bus.m_bready    = bus.s_bready[i];
        end
      end
    end
  end

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_gnt_d = rd_gnt_q;
    wr_st_d  = wr_st_q;
    wr_gnt_d = wr_gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rd_last_d = rd_last_q;
    wr_last_d = wr_last_q;
`endif
    unique case (rd_st_q)
      R_IDLE: if (|bus.s_arvalid) begin
        rd_gnt_d = rd_pick;
        rd_st_d  = R_ADDR;
      end
      R_ADDR: if (bus.m_arvalid && bus.m_arready) rd_st_d = R_DATA;
      R_DATA: if (bus.m_rvalid && bus.m_rready && bus.m_rlast) begin
        rd_st_d = R_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        rd_last_d = rd_gnt_q;
`endif
      end
      default: rd_st_d = R_IDLE;
    endcase
    unique case (wr_st_q)
      W_IDLE: if (|bus.s_awvalid) begin
        wr_gnt_d = wr_pick;
        wr_st_d  = W_ADDR;
      end
      W_ADDR: if (bus.m_awvalid && bus.m_awready) wr_st_d = W_DATA;
      W_DATA: if (bus.m_wvalid && bus.m_wready && bus.m_wlast) wr_st_d = W_RESP;
      W_RESP: if (bus.m_bvalid && bus.m_bready) begin
        wr_st_d = W_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        wr_last_d = wr_gnt_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_st_q  <= R_IDLE;
      wr_st_q  <= W_IDLE;
      rd_gnt_q <= '0;
      wr_gnt_q <= '0;
    end else begin
      rd_st_q  <= rd_st_d;
      wr_st_q  <= wr_st_d;
      rd_gnt_q <= rd_gnt_d;
      wr_gnt_q <= wr_gnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_last_q <= GW'(NM - 1);
      wr_last_q <= GW'(NM - 1);
    end else begin
      rd_last_q <= rd_last_d;
      wr_last_q <= wr_last_d;
    end
  end
`endif

endmodule
